// File: rtl/mem_access_unit.sv
// Load/store sequencer for the single-port data memory: one request at a time, one beat per cycle.
// Optional readback check after every store beat is enabled by defining MAU_READBACK_VERIFY_EN.
module mem_access_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_len,
  input  logic [4*DATA_W-1:0] req_wdata,
  output logic                resp_valid,
  output logic [4*DATA_W-1:0] resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   writeData,
  output logic                MemRead,
  output logic                MemWrite,
  input  logic [DATA_W-1:0]   dataOut
);

  localparam int WORD_W = 4 * DATA_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
`ifdef MAU_READBACK_VERIFY_EN
    VERIFY = 3'd3,
`endif
    DONE   = 3'd4
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   base_r;
  logic [1:0]          len_r;
  logic [1:0]          beat_r;
  logic [WORD_W-1:0]   wdata_r;
  logic [WORD_W-1:0]   rdata_r;
  logic [1:0]          next_beat_s;

  function automatic logic [DATA_W-1:0] get_byte(input logic [WORD_W-1:0] w, input logic [1:0] k);
    return w[DATA_W*int'(k) +: DATA_W];
  endfunction

  function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] w, input logic [1:0] k,
                                                 input logic [DATA_W-1:0] b);
    logic [WORD_W-1:0] r;
    r = w;
    r[DATA_W*int'(k) +: DATA_W] = b;
    return r;
  endfunction

  // Beat addresses wrap modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base, input logic [1:0] k);
    return base + ADDR_W'(k);
  endfunction

  assign next_beat_s = beat_r + 2'd1;

`ifdef MAU_READBACK_VERIFY_EN
  logic err_r;
  logic mismatch_s;
  assign mismatch_s = (dataOut != get_byte(wdata_r, beat_r));
`else
  assign resp_err = 1'b0;
`endif

  // Request sequencer: state, beat counter, capture register and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      base_r     <= '0;
      len_r      <= 2'd0;
      beat_r     <= 2'd0;
      wdata_r    <= '0;
      rdata_r    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      address    <= '0;
      writeData  <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
`ifdef MAU_READBACK_VERIFY_EN
      err_r      <= 1'b0;
      resp_err   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid && req_ready) begin
            base_r     <= req_addr;
            len_r      <= req_len;
            wdata_r    <= req_wdata;
            beat_r     <= 2'd0;
            rdata_r    <= '0;
            resp_rdata <= '0;
            req_ready  <= 1'b0;
            address    <= req_addr;
`ifdef MAU_READBACK_VERIFY_EN
            err_r      <= 1'b0;
            resp_err   <= 1'b0;
`endif
            if (req_write) begin
              state_r   <= WRITE;
              MemWrite  <= 1'b1;
              writeData <= req_wdata[DATA_W-1:0];
            end else begin
              state_r   <= READ;
              MemRead   <= 1'b1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        READ: begin
          rdata_r <= put_byte(rdata_r, beat_r, dataOut);
          if (beat_r == len_r) begin
            state_r    <= DONE;
            MemRead    <= 1'b0;
            address    <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= put_byte(rdata_r, beat_r, dataOut);
          end else begin
            beat_r  <= next_beat_s;
            address <= beat_addr(base_r, next_beat_s);
          end
        end

        WRITE: begin
`ifdef MAU_READBACK_VERIFY_EN
          // Re-read the byte just committed, same address.
          state_r  <= VERIFY;
          MemWrite <= 1'b0;
          MemRead  <= 1'b1;
`else
          if (beat_r == len_r) begin
            state_r    <= DONE;
            MemWrite   <= 1'b0;
            address    <= '0;
            writeData  <= '0;
            resp_valid <= 1'b1;
          end else begin
            beat_r    <= next_beat_s;
            address   <= beat_addr(base_r, next_beat_s);
            writeData <= get_byte(wdata_r, next_beat_s);
          end
`endif
        end

`ifdef MAU_READBACK_VERIFY_EN
        VERIFY: begin
          err_r   <= err_r | mismatch_s;
          MemRead <= 1'b0;
          if (beat_r == len_r) begin
            state_r    <= DONE;
            address    <= '0;
            writeData  <= '0;
            resp_valid <= 1'b1;
            resp_err   <= err_r | mismatch_s;
          end else begin
            state_r   <= WRITE;
            MemWrite  <= 1'b1;
            beat_r    <= next_beat_s;
            address   <= beat_addr(base_r, next_beat_s);
            writeData <= get_byte(wdata_r, next_beat_s);
          end
        end
`endif

        DONE: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state_r    <= IDLE;
        end

        default: begin
          state_r    <= IDLE;
          req_ready  <= 1'b0;
          resp_valid <= 1'b0;
          address    <= '0;
          writeData  <= '0;
          MemRead    <= 1'b0;
          MemWrite   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural 16x8 data memory.
module tb_mem_access_unit;

`ifdef MAU_READBACK_VERIFY_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr = 4'd0;
  logic [1:0]  req_len = 2'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  address;
  logic [7:0]  writeData;
  logic        MemRead;
  logic        MemWrite;
  logic [7:0]  dataOut = 8'd0;

  logic [7:0]  mem [16];
  logic [7:0]  wmask = 8'hFF;
  logic        overlap = 1'b0;
  logic        addr0_seen = 1'b0;
  int          errors = 0;
  int          checks = 0;

  mem_access_unit dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .address(address), .writeData(writeData), .MemRead(MemRead), .MemWrite(MemWrite),
    .dataOut(dataOut)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (MemWrite) mem[address] <= writeData & wmask;
  always @(negedge clock) if (MemRead) dataOut <= mem[address];
  always @(negedge clock) begin
    if (MemRead && MemWrite) overlap <= 1'b1;
    if ((MemRead || MemWrite) && address == 4'd0) addr0_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait (bounded) for req_ready, present the request for one accept edge, return in cycle 1.
  task automatic do_req(input logic w, input logic [3:0] a, input logic [1:0] l, input logic [31:0] d);
    int guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) chk("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_addr [4];
    logic [7:0] exp_data [4];
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'd1; mem[1] = 8'd15; mem[2] = 8'd5;

    // Reset state
    #3;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_strobes", 32'({MemRead, MemWrite, resp_valid, resp_err}), 32'd0);
    chk("rst_addr_data", 32'({address, writeData}), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Load base 0, len 2
    do_req(1'b0, 4'd0, 2'd2, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("load_memread", 32'({MemRead, MemWrite}), 32'b10);
      chk("load_addr", 32'(address), 32'(k));
      tick();
    end
    chk("load_resp_valid", 32'(resp_valid), 32'd1);
    chk("load_strobes_off", 32'({MemRead, address}), 32'd0);
    chk("load_rdata", resp_rdata, 32'h00050F01);
    tick();
    chk("load_resp_pulse", 32'({resp_valid, req_ready}), 32'b01);
    chk("load_rdata_hold", resp_rdata, 32'h00050F01);

    // Store base 14, len 3 wraps to 0 and 1
    exp_addr[0] = 4'd14; exp_addr[1] = 4'd15; exp_addr[2] = 4'd0; exp_addr[3] = 4'd1;
    exp_data[0] = 8'hAA; exp_data[1] = 8'hBB; exp_data[2] = 8'hCC; exp_data[3] = 8'hDD;
    do_req(1'b1, 4'd14, 2'd3, 32'hDDCCBBAA);
    for (int k = 0; k < 4; k++) begin
      chk("store_strobe", 32'({MemRead, MemWrite}), 32'b01);
      chk("store_addr", 32'(address), 32'(exp_addr[k]));
      chk("store_wdata", 32'(writeData), 32'(exp_data[k]));
      tick();
      if (SC == 2) begin
        chk("verify_strobe", 32'({MemRead, MemWrite, address}), 32'({2'b10, exp_addr[k]}));
        tick();
      end
    end
    chk("store_resp", 32'({resp_valid, resp_err}), 32'b10);
    chk("store_rdata_zero", resp_rdata, 32'd0);
    chk("store_mem", 32'({mem[1], mem[0], mem[15], mem[14]}), 32'hDDCCBBAA);
    tick();

    do_req(1'b0, 4'd14, 2'd3, 32'd0);
    tick_n(4);
    chk("wrap_load_resp", 32'(resp_valid), 32'd1);
    chk("wrap_load_rdata", resp_rdata, 32'hDDCCBBAA);

    // req_valid held across a busy store: second request taken only in cycle SC*2+2
    do_req(1'b1, 4'd4, 2'd1, 32'h00002211);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd4; req_len = 2'd1;
    for (int c = 1; c <= SC * 2 + 1; c++) begin
      chk("busy_not_ready", 32'(req_ready), 32'd0);
      tick();
    end
    chk("busy_ready_again", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("held_req_accepted", 32'({MemRead, MemWrite, address}), 32'({2'b10, 4'd4}));
    tick_n(2);
    chk("held_req_resp", 32'(resp_valid), 32'd1);
    chk("held_req_rdata", resp_rdata, 32'h00002211);
    chk("no_overlap", 32'(overlap), 32'd0);
    tick();

    // Reset mid-way through cycle 2 of a 4-beat store
    do_req(1'b1, 4'd8, 2'd3, 32'h44332211);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("abort_strobes", 32'({MemRead, MemWrite, writeData, address}), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    #3 reset_n = 1'b1;
    #4;
    chk("abort_ready_after", 32'({req_ready, resp_valid}), 32'b10);
    tick();
    chk("abort_no_resp", 32'(resp_valid), 32'd0);
    chk("abort_mem", 32'({mem[11], mem[10], mem[9], mem[8]}), 32'h00000011);

    // Single-byte load/store at address 15
    addr0_seen = 1'b0;
    do_req(1'b0, 4'd15, 2'd0, 32'd0);
    chk("single_load_beat", 32'({MemRead, address}), 32'({1'b1, 4'd15}));
    tick();
    chk("single_load_resp", 32'(resp_valid), 32'd1);
    chk("single_load_rdata", resp_rdata, 32'h000000BB);
    tick();
    do_req(1'b1, 4'd15, 2'd0, 32'h00000077);
    tick_n(SC);
    chk("single_store_resp", 32'(resp_valid), 32'd1);
    chk("single_store_mem", 32'({mem[0], mem[15]}), 32'h0000CC77);
    chk("no_addr0_access", 32'(addr0_seen), 32'd0);
    tick();

`ifdef MAU_READBACK_VERIFY_EN
    // Readback against a memory whose bit 0 is stuck at 0
    wmask = 8'hFE;
    do_req(1'b1, 4'd3, 2'd0, 32'h00000001);
    tick_n(2);
    chk("verify_err_set", 32'({resp_valid, resp_err}), 32'b11);
    tick();
    do_req(1'b1, 4'd3, 2'd0, 32'h00000002);
    tick_n(2);
    chk("verify_err_clear", 32'({resp_valid, resp_err}), 32'b10);
    wmask = 8'hFF;
`else
    chk("err_tied_low", 32'(resp_err), 32'd0);
`endif
    chk("no_overlap_end", 32'(overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that drives the processor's single-port data memory (4-bit address, 8-bit data, read on negedge, write on posedge, `MemRead`/`MemWrite` strobes). Accepts one request at a time from the datapath (single byte or burst of up to 4 consecutive bytes), sequences the memory strobes one beat per cycle, and returns packed read data plus a completion pulse. Sits between the control unit/register file and the data memory.

## Interface
Parameters:
- `ADDR_W`, 4, memory address width; addresses wrap modulo 2^ADDR_W
- `DATA_W`, 8, memory data width; request/response words are 4*DATA_W

Ports:
- `clock`  in  1  rising-edge system clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle, request accepted on `req_valid && req_ready` at posedge
- `req_write`  in  1  1 = store burst, 0 = load burst
- `req_addr`  in  ADDR_W  base address of beat 0
- `req_len`  in  2  number of beats minus 1 (0..3)
- `req_wdata`  in  4*DATA_W  store bytes; byte k → address base+k
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  4*DATA_W  load bytes; byte k from base+k, unused bytes zero
- `resp_err`  out  1  readback mismatch (valid with `resp_valid`; 0 when macro absent)
- `address`  out  ADDR_W  to memory
- `writeData`  out  DATA_W  to memory
- `MemRead`  out  1  to memory
- `MemWrite`  out  1  to memory
- `dataOut`  in  DATA_W  from memory

## Operation
- States: IDLE, READ, WRITE, VERIFY (macro only), DONE.
- IDLE: `req_ready`=1; on accept latch write flag, base, length, wdata; clear beat counter, capture register, error flag; go READ or WRITE.
- READ beat k: `MemRead`=1, `address`=base+k; capture `dataOut` into byte k at the closing posedge; k==len → DONE else k+1.
- WRITE beat k: `MemWrite`=1, `address`=base+k, `writeData`=byte k; memory commits at closing posedge; then VERIFY (macro) or next beat / DONE.
- DONE: `resp_valid`=1 for one cycle, `req_ready`=0, then IDLE.
- `MemRead` and `MemWrite` never high together; both 0 outside READ/WRITE/VERIFY; `address`, `writeData` = 0 in IDLE/DONE.
- Address arithmetic: base+k truncated to ADDR_W bits (14,15,0,1 for base 14, len 3).
- `resp_rdata` and `resp_err` hold their values until next accept; store response leaves `resp_rdata` = 0.
- `req_valid` while busy is ignored (not queued); requester holds it until `req_ready`.
- Reset (any state, any cycle): all outputs 0 immediately, state IDLE; an in-flight beat is abandoned (a store whose `MemWrite` drops before its posedge does not commit); no `resp_valid` issued for the aborted request.

## Timing
- Accept edge T0; beats occupy cycles 1..L (L = `req_len`+1); `resp_valid` in cycle L+1; `req_ready` high in cycle L+2.
- Load: byte k valid internally at end of cycle k+1 (memory drives `dataOut` at mid-cycle negedge).
- Store without macro: L+2 cycles request-to-request; with macro: each beat takes 2 cycles, `resp_valid` in cycle 2L+1.
- Minimum back-to-back throughput: one single-byte request every 3 cycles.

## Configuration
- `MAU_READBACK_VERIFY_EN` defined: after each WRITE beat, one VERIFY cycle with `MemRead`=1 at the same address; `dataOut` compared to the written byte at the closing posedge; any mismatch sets the sticky error reported on `resp_err` at DONE.
- Undefined: VERIFY state absent, WRITE proceeds directly to next beat/DONE, `resp_err` tied 0.

## Test plan
- Memory preloaded data[0]=1, data[1]=15, data[2]=5; load base 0, len 2 → `resp_valid` in cycle 4, `resp_rdata`=0x00050F01, `MemRead` high exactly cycles 1–3 with address 0,1,2.
- Store base 14, len 3, wdata 0xDDCCBBAA → mem[14]=0xAA, mem[15]=0xBB, mem[0]=0xCC, mem[1]=0xDD; following load base 14 len 3 returns 0xDDCCBBAA.
- `req_valid` held during busy store → `req_ready`=0, second request accepted only in cycle L+2; no strobe overlap, no lost request.
- `reset_n` pulsed low mid-way through cycle 2 of a 4-beat store → strobes drop asynchronously, only beat 0 committed, no `resp_valid`, `req_ready`=1 after release.
- With `MAU_READBACK_VERIFY_EN`, memory model forcing bit 0 stuck-at-0, store 0x01 to address 3 → `resp_err`=1 with `resp_valid` in cycle 3; store 0x02 → `resp_err`=0.
- Single-byte load/store at address 15, len 0 → one beat, `resp_valid` in cycle 2, no access to address 0.
